// File: rtl/gpu_mem_pkg.sv
// Shared constants and FSM encoding for the VRAM rectangle path
// (arbiter, address generator, VRAM port arbiter).
package gpu_mem_pkg;

    localparam int COORD_W     = 16;
    localparam int PIXEL_BURST = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // A rectangle with either dimension zero carries no beats.
    function automatic logic is_empty_rect(input logic [COORD_W-1:0] sizex,
                                           input logic [COORD_W-1:0] sizey);
        return (sizex == '0) || (sizey == '0);
    endfunction

endpackage

// File: rtl/gpu_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping, returned as one-hot and as an index.
module gpu_rr_pick #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] cand;

    // Walk from the farthest slot back toward ptr_i so the nearest hit wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        cand     = '0;
        any_o    = |req_i;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                onehot_o       = '0;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

endmodule

// File: rtl/gpu_mem_rect_arbiter.sv
// Round-robin owner of the VRAM rectangle address generator: captures one
// requester's rectangle, starts the generator, steers beats, signals done.
module gpu_mem_rect_arbiter
    import gpu_mem_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ-1:0]         req_incr_i,
    input  logic [COORD_W*NUM_REQ-1:0] req_x_i,
    input  logic [COORD_W*NUM_REQ-1:0] req_y_i,
    input  logic [COORD_W*NUM_REQ-1:0] req_sizex_i,
    input  logic [COORD_W*NUM_REQ-1:0] req_sizey_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         grant_o,
    input  logic [NUM_REQ-1:0]         beat_accept_i,
    output logic [NUM_REQ-1:0]         done_o,
    output logic                       gen_start_o,
    output logic                       gen_incr_o,
    output logic [COORD_W-1:0]         gen_x_o,
    output logic [COORD_W-1:0]         gen_y_o,
    output logic [COORD_W-1:0]         gen_sizex_o,
    output logic [COORD_W-1:0]         gen_sizey_o,
    input  logic                       gen_valid_i,
    input  logic                       gen_last_i,
    output logic                       gen_accept_o,
    output logic [1:0]                 dbg_state_o
);

    arb_state_e          state_q;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  grant_q;
    logic [COORD_W-1:0]  x_q, y_q, sizex_q, sizey_q;
    logic                incr_q;

    logic [NUM_REQ-1:0]  win_oh;
    logic [PW-1:0]       win_idx;
    logic                win_any;
    logic [COORD_W-1:0]  sel_x, sel_y, sel_sizex, sel_sizey;
    logic                sel_incr;

    gpu_rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i    (req_valid_i),
        .ptr_i    (rr_ptr_q),
        .onehot_o (win_oh),
        .idx_o    (win_idx),
        .any_o    (win_any)
    );

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_sizex = '0;
        sel_sizey = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_x     = req_x_i[i*COORD_W +: COORD_W];
                sel_y     = req_y_i[i*COORD_W +: COORD_W];
                sel_sizex = req_sizex_i[i*COORD_W +: COORD_W];
                sel_sizey = req_sizey_i[i*COORD_W +: COORD_W];
            end
        end
        sel_incr = |(win_oh & req_incr_i);
        rr_ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end

    // Handshakes: a request transfers in the cycle req_valid_i[i] and
    // req_ready_o[i] are both high; a beat transfers when gen_valid_i and
    // gen_accept_o are both high. Valid, once raised, holds until transfer.
    assign req_ready_o  = (state_q == ST_IDLE) ? win_oh : '0;
    assign gen_accept_o = (state_q == ST_RUN) && |(grant_q & beat_accept_i);
    assign gen_start_o  = (state_q == ST_START);
    assign done_o       = (state_q == ST_DONE) ? grant_q : '0;
    assign grant_o      = grant_q;
    assign gen_incr_o   = incr_q;
    assign gen_x_o      = x_q;
    assign gen_y_o      = y_q;
    assign gen_sizex_o  = sizex_q;
    assign gen_sizey_o  = sizey_q;
    assign dbg_state_o  = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sizex_q  <= '0;
            sizey_q  <= '0;
            incr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_any) begin
                        x_q      <= sel_x;
                        y_q      <= sel_y;
                        sizex_q  <= sel_sizex;
                        sizey_q  <= sel_sizey;
                        incr_q   <= sel_incr;
                        grant_q  <= win_oh;
                        rr_ptr_q <= rr_ptr_d;
                        // Empty rectangles skip the generator entirely.
                        state_q  <= is_empty_rect(sel_sizex, sel_sizey) ? ST_DONE : ST_START;
                    end
                end
                ST_START: state_q <= ST_RUN;
                ST_RUN: begin
                    if (gen_valid_i && gen_last_i && gen_accept_o) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_mem_rect_arbiter.sv
// Directed bench for gpu_mem_rect_arbiter: acts as requesters and generator,
// checks every cycle against a transaction-level model of the arbiter.
module tb_gpu_mem_rect_arbiter;
    import gpu_mem_pkg::*;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_i;

    logic [N-1:0]    req_valid_i, req_incr_i, req_ready_o, grant_o, beat_accept_i, done_o;
    logic [16*N-1:0] req_x_i, req_y_i, req_sizex_i, req_sizey_i;
    logic            gen_start_o, gen_incr_o, gen_valid_i, gen_last_i, gen_accept_o;
    logic [15:0]     gen_x_o, gen_y_o, gen_sizex_o, gen_sizey_o;
    logic [1:0]      dbg_state;

    gpu_mem_rect_arbiter #(.NUM_REQ(N)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_incr_i(req_incr_i),
        .req_x_i(req_x_i), .req_y_i(req_y_i),
        .req_sizex_i(req_sizex_i), .req_sizey_i(req_sizey_i),
        .req_ready_o(req_ready_o), .grant_o(grant_o),
        .beat_accept_i(beat_accept_i), .done_o(done_o),
        .gen_start_o(gen_start_o), .gen_incr_o(gen_incr_o),
        .gen_x_o(gen_x_o), .gen_y_o(gen_y_o),
        .gen_sizex_o(gen_sizex_o), .gen_sizey_o(gen_sizey_o),
        .gen_valid_i(gen_valid_i), .gen_last_i(gen_last_i),
        .gen_accept_o(gen_accept_o), .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return (i >= 0) ? (N'(1) << i) : '0;
    endfunction

    // ---------------- behavioural model + compare ----------------
    int          m_owner = -1, m_ptr = 0, m_start = -1, m_done = -1, cyc = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_x = '0, m_y = '0, m_sx = '0, m_sy = '0;
    logic        m_incr = 1'b0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    initial begin
        forever begin
            int w;
            bit running;
            @(negedge clk);
            w = (m_owner < 0) ? pick(req_valid_i, m_ptr) : -1;
            running = (m_owner >= 0) && (m_start >= 0) && (cyc > m_start) && (m_done < 0);
            if (m_valid) begin
                chk("req_ready", 32'(req_ready_o), 32'(oh(w)));
                chk("grant", 32'(grant_o), 32'(oh(m_owner)));
                chk("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
                chk("gen_start", 32'(gen_start_o), 32'(cyc == m_start));
                chk("gen_accept", 32'(gen_accept_o), 32'(running ? beat_accept_i[m_owner] : 1'b0));
                chk("done", 32'(done_o), 32'((cyc == m_done) ? oh(m_owner) : '0));
                chk("gen_x", 32'(gen_x_o), 32'(m_x));
                chk("gen_y", 32'(gen_y_o), 32'(m_y));
                chk("gen_sizex", 32'(gen_sizex_o), 32'(m_sx));
                chk("gen_sizey", 32'(gen_sizey_o), 32'(m_sy));
                chk("gen_incr", 32'(gen_incr_o), 32'(m_incr));
            end
            if (rst_i) begin
                m_owner = -1; m_ptr = 0; m_start = -1; m_done = -1;
                m_x = '0; m_y = '0; m_sx = '0; m_sy = '0; m_incr = 1'b0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                if (m_owner < 0) begin
                    if (w >= 0) begin
                        m_owner = w;
                        m_ptr   = (w + 1) % N;
                        m_x  = req_x_i[16*w +: 16];
                        m_y  = req_y_i[16*w +: 16];
                        m_sx = req_sizex_i[16*w +: 16];
                        m_sy = req_sizey_i[16*w +: 16];
                        m_incr = req_incr_i[w];
                        if (m_sx == 0 || m_sy == 0) begin
                            m_done = cyc + 1; m_start = -1;
                        end else begin
                            m_start = cyc + 1; m_done = -1;
                        end
                    end
                end else if (cyc == m_done) begin
                    m_owner = -1; m_done = -1; m_start = -1;
                end else if (running && gen_valid_i && gen_last_i && beat_accept_i[m_owner]) begin
                    m_done = cyc + 1;
                end
            end
            cyc++;
        end
    end

    // ---------------- driver: requesters + generator ----------------
    logic [N-1:0] rearm = '0;
    int tcyc = 0, ready_cyc = -1, start_cyc = -1, lasths_cyc = -1, done_cyc = -1;
    int beats = 0, starts = 0, gen_left = 0;
    logic [N-1:0] done_log[$];
    logic [N-1:0] exp_q[$];

    task automatic tick();
        logic [N-1:0] s_ready, s_done;
        logic         s_start, s_hs, s_last, s_rst;
        logic [15:0]  s_sx, s_sy;
        @(negedge clk);
        s_ready = req_ready_o; s_done = done_o; s_start = gen_start_o;
        s_hs = gen_valid_i & gen_accept_o; s_last = gen_last_i; s_rst = rst_i;
        s_sx = gen_sizex_o; s_sy = gen_sizey_o;
        if (s_ready != 0) ready_cyc = tcyc;
        if (s_start) begin start_cyc = tcyc; starts++; end
        if (s_hs) begin beats++; if (s_last) lasths_cyc = tcyc; end
        if (s_done != 0) begin done_cyc = tcyc; done_log.push_back(s_done); end
        @(posedge clk);
        #1;
        req_valid_i = req_valid_i & ~(s_ready & ~rearm);
        if (s_rst) gen_left = 0;
        else if (s_start) gen_left = ((int'(s_sx) + PIXEL_BURST - 1) / PIXEL_BURST) * int'(s_sy);
        else if (s_hs) gen_left--;
        gen_valid_i = (gen_left > 0);
        gen_last_i  = (gen_left == 1);
        tcyc++;
    endtask

    task automatic post(input int i, input int x, input int y, input int sx, input int sy, input bit incr);
        req_x_i[16*i +: 16]     = 16'(x);
        req_y_i[16*i +: 16]     = 16'(y);
        req_sizex_i[16*i +: 16] = 16'(sx);
        req_sizey_i[16*i +: 16] = 16'(sy);
        req_incr_i[i]  = incr;
        req_valid_i[i] = 1'b1;
    endtask

    task automatic clear_logs();
        done_log.delete(); beats = 0; starts = 0;
    endtask

    task automatic do_reset();
        req_valid_i = '0;
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        clear_logs();
    endtask

    task automatic wait_dones(input int n, input int budget, input string name);
        int k = 0;
        while (done_log.size() < n && k < budget) begin tick(); k++; end
        chk({name, "_timeout"}, 32'(done_log.size() >= n), 32'd1);
    endtask

    task automatic check_order(input string name);
        while (exp_q.size() > 0) begin
            logic [N-1:0] e;
            e = exp_q.pop_front();
            if (done_log.size() > 0) chk(name, 32'(done_log.pop_front()), 32'(e));
            else chk({name, "_missing"}, 32'(0), 32'(e));
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int k;
        int b0;
        rst_i = 1'b1; req_valid_i = '0; req_incr_i = '0; beat_accept_i = '1;
        req_x_i = '0; req_y_i = '0; req_sizex_i = '0; req_sizey_i = '0;
        gen_valid_i = 1'b0; gen_last_i = 1'b0;
        do_reset();

        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_start", 32'(gen_start_o), 32'd0);
        chk("rst_accept", 32'(gen_accept_o), 32'd0);
        chk("rst_sizex", 32'(gen_sizex_o), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);

        // single 32x2 rectangle: 2 bursts per row, 2 rows
        post(0, 0, 0, 32, 2, 1'b1);
        wait_dones(1, 50, "t1");
        chk("t1_beats", 32'(beats), 32'd4);
        chk("t1_starts", 32'(starts), 32'd1);
        chk("t1_start_lat", 32'(start_cyc - ready_cyc), 32'd1);
        chk("t1_done_lat", 32'(done_cyc - lasths_cyc), 32'd1);
        chk("t1_done_vec", 32'(done_log.size() > 0 ? done_log[0] : '0), 32'h1);
        tick(); tick();

        // all four at once from a fresh pointer
        do_reset();
        for (int i = 0; i < N; i++) post(i, 100 * i, i, 16, 1, 1'b1);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        wait_dones(4, 100, "t2");
        chk("t2_beats", 32'(beats), 32'd4);
        check_order("t2_order");
        tick();

        // zero-width rectangle on requester 2
        clear_logs();
        post(2, 5, 6, 0, 5, 1'b1);
        wait_dones(1, 20, "t3");
        chk("t3_done_lat", 32'(done_cyc - ready_cyc), 32'd1);
        chk("t3_starts", 32'(starts), 32'd0);
        chk("t3_done_vec", 32'(done_log.size() > 0 ? done_log[0] : '0), 32'h4);
        tick();

        // backpressure from the granted requester while requester 3 accepts
        clear_logs();
        post(1, 40, 9, 64, 1, 1'b0);
        k = 0;
        while (beats < 1 && k < 30) begin tick(); k++; end
        chk("t4_first_beat", 32'(beats >= 1), 32'd1);
        beat_accept_i = 4'b1101;
        b0 = beats;
        for (int i = 0; i < 5; i++) tick();
        chk("t4_stall_beats", 32'(beats), 32'(b0));
        beat_accept_i = '1;
        wait_dones(1, 50, "t4");
        chk("t4_beats", 32'(beats), 32'd4);
        chk("t4_done_vec", 32'(done_log.size() > 0 ? done_log[0] : '0), 32'h2);
        tick();

        // fairness: requester 0 re-asserts at once, requester 3 arrives mid-run
        clear_logs();
        rearm = 4'b0001;
        post(0, 1, 1, 32, 1, 1'b1);
        k = 0;
        while (starts < 1 && k < 30) begin tick(); k++; end
        tick();
        post(3, 7, 7, 16, 1, 1'b1);
        wait_dones(2, 100, "t5a");
        rearm = '0;
        wait_dones(3, 100, "t5b");
        exp_q.push_back(4'b0001); exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        check_order("t5_order");
        tick(); tick();

        // reset during RUN, then pointer must restart at 0
        clear_logs();
        post(2, 3, 3, 64, 1, 1'b1);
        k = 0;
        while (beats < 2 && k < 30) begin tick(); k++; end
        chk("t6_two_beats", 32'(beats), 32'd2);
        req_valid_i = '0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t6_grant", 32'(grant_o), 32'd0);
        chk("t6_accept", 32'(gen_accept_o), 32'd0);
        chk("t6_done", 32'(done_o), 32'd0);
        chk("t6_start", 32'(gen_start_o), 32'd0);
        chk("t6_sizex", 32'(gen_sizex_o), 32'd0);
        tick(); tick();
        chk("t6_no_done", 32'(done_log.size()), 32'd0);
        post(1, 2, 2, 16, 1, 1'b1);
        post(3, 4, 4, 16, 1, 1'b1);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b1000);
        wait_dones(2, 100, "t6");
        check_order("t6_order");
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
